// File: rtl/newtpla1_onset_gen.sv
// Sequential enumerator for the newtpla1 function: walks all 1024 input vectors
// and streams those whose function value equals POLARITY over a valid/ready port.
module newtpla1_onset_gen #(
  parameter bit POLARITY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        vec_valid,
  input  logic        vec_ready,
  output logic [9:0]  vec,
  output logic [10:0] emit_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t      state, state_n;
  logic [9:0]  idx, idx_n;
  logic [9:0]  vec_p1, vec_n;
  logic        vld_p1, vld_n;
  logic [10:0] cnt, cnt_n;
  logic        hs, match, slot_free;

  function automatic logic eval_f(input logic [9:0] x);
    return ~x[1] & ~x[3] & ~x[4] & ~x[5] & x[6] & x[7] &
           (x[0] ? (x[2] & x[9]) : x[8]);
  endfunction

  assign hs        = vld_p1 & vec_ready;
  assign match     = (eval_f(idx) == POLARITY);
  assign slot_free = ~vld_p1 | hs;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    vec_n   = vec_p1;
    vld_n   = vld_p1;
    cnt_n   = cnt + {10'd0, hs};
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SCAN;
          idx_n   = 10'd0;
          cnt_n   = 11'd0;
        end
      end
      SCAN: begin
        if (hs) vld_n = 1'b0;
        // A match with the output slot occupied stalls on the same candidate.
        if (!match || slot_free) begin
          if (match) begin
            vec_n = idx;
            vld_n = 1'b1;
          end
          if (idx == 10'd1023) state_n = DRAIN;
          else                 idx_n   = idx + 10'd1;
        end
      end
      DRAIN: begin
        if (hs) vld_n = 1'b0;
        if (slot_free) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Abort overrides everything but reset, including a same-cycle start.
    if (abort) begin
      state_n = IDLE;
      vld_n   = 1'b0;
      idx_n   = idx;
      cnt_n   = cnt + {10'd0, hs};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 10'd0;
      vec_p1 <= 10'd0;
      vld_p1 <= 1'b0;
      cnt    <= 11'd0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      vec_p1 <= vec_n;
      vld_p1 <= vld_n;
      cnt    <= cnt_n;
    end
  end

  assign busy       = (state == SCAN) || (state == DRAIN);
  assign done       = (state == DONE);
  assign vec_valid  = vld_p1;
  assign vec        = vec_p1;
  assign emit_count = cnt;

endmodule

// File: tb/tb_newtpla1_onset_gen.sv
// Directed bench for newtpla1_onset_gen: onset and offset enumeration, back-pressure,
// abort, reset and start-filtering behaviour.
module tb_newtpla1_onset_gen;

  logic        clk;
  logic        rst;
  logic        start1, abort1, ready1;
  logic        busy1, done1, vv1;
  logic [9:0]  vec1;
  logic [10:0] cnt1;
  logic        start0, abort0, ready0;
  logic        busy0, done0, vv0;
  logic [9:0]  vec0;
  logic [10:0] cnt0;

  newtpla1_onset_gen #(.POLARITY(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .busy(busy1), .done(done1),
    .vec_valid(vv1), .vec_ready(ready1), .vec(vec1), .emit_count(cnt1));

  newtpla1_onset_gen #(.POLARITY(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .busy(busy0), .done(done0),
    .vec_valid(vv0), .vec_ready(ready0), .vec(vec0), .emit_count(cnt0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [9:0] v;
  } exp_t;
  exp_t tbl[6];

  int total = 0;
  int passed = 0;

  logic [9:0] q1[$];
  logic [9:0] q0[$];
  int done_cnt1 = 0;
  int stab_err = 0;
  logic prev_stall = 1'b0;
  logic [9:0] prev_vec = 10'd0;

  // Handshakes and hold-stability are observed mid-cycle, when inputs are settled.
  always @(negedge clk) begin
    if (vv1 && ready1) q1.push_back(vec1);
    if (vv0 && ready0) q0.push_back(vec0);
    if (done1) done_cnt1 <= done_cnt1 + 1;
    if (prev_stall && !(vv1 && vec1 == prev_vec)) stab_err <= stab_err + 1;
    prev_stall <= vv1 && !ready1 && !rst && !abort1;
    prev_vec   <= vec1;
  end

  function automatic logic f_model(input logic [9:0] x);
    logic r;
    r = (x[7:6] == 2'b11) && (x[5:3] == 3'b000) && !x[1];
    if (x[0]) r = r && x[2] && x[9];
    else      r = r && x[8];
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_seq(input string tag, input int base);
    int mism;
    mism = 0;
    check({tag, "_len"}, q1.size() - base, 6);
    for (int i = 0; i < 6; i++)
      if (q1.size() <= base + i || q1[base + i] != tbl[i].v) begin
        mism++;
        $display("FAIL %s_%s: got %0d expected %0d", tag, tbl[i].name,
                 (q1.size() > base + i) ? int'(q1[base + i]) : -1, tbl[i].v);
      end
    check({tag, "_mismatches"}, mism, 0);
    check({tag, "_emit_count"}, cnt1, 6);
  endtask

  // mode 0: ready held high; 1: random ready with a 20-cycle hold on 960; 2: start re-pulsed
  task automatic run_scan(input int mode, output int dn, output int first_vv,
                          output int bz_done, output int bz_prev, output int hold);
    logic pb;
    dn = 0; first_vv = 0; bz_done = -1; bz_prev = -1; hold = 0; pb = 1'b0;
    ready1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int n = 1; n <= 4000 && dn == 0; n++) begin
      @(negedge clk);
      if (first_vv == 0 && vv1) first_vv = n;
      if (done1) begin
        dn = n; bz_done = int'(busy1); bz_prev = int'(pb);
      end
      pb = busy1;
      @(posedge clk); #1;
      if (mode == 1) begin
        if (vv1 && vec1 == 10'd960 && hold < 20) begin
          ready1 = 1'b0; hold++;
        end else if (vv1 && vec1 == 10'd960) ready1 = 1'b1;
        else ready1 = 1'($urandom_range(0, 1));
      end
      if (mode == 2) start1 = (n == 99);
    end
    start1 = 1'b0;
    ready1 = 1'b1;
    if (dn == 0) $display("FAIL scan_timeout: got no done expected done");
  endtask

  initial begin
    int dn, fv, bzd, bzp, hold, base, d0, mism, hits, hit;
    logic [9:0] exp0[$];

    tbl[0] = '{"v0", 10'd448};
    tbl[1] = '{"v1", 10'd452};
    tbl[2] = '{"v2", 10'd709};
    tbl[3] = '{"v3", 10'd960};
    tbl[4] = '{"v4", 10'd964};
    tbl[5] = '{"v5", 10'd965};

    rst = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
    start0 = 1'b0; abort0 = 1'b0; ready0 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_valid", vv1, 0);
    check("rst_vec", vec1, 0);
    check("rst_count", cnt1, 0);
    check("rst_busy_p0", busy0, 0);

    // Onset scan with ready held high.
    base = q1.size(); d0 = done_cnt1;
    run_scan(0, dn, fv, bzd, bzp, hold);
    check("s1_first_valid_cycle", fv, 450);
    check("s1_done_cycle", dn, 1026);
    check("s1_busy_at_done", bzd, 0);
    check("s1_busy_before_done", bzp, 1);
    repeat (4) @(negedge clk);
    check("s1_done_pulses", done_cnt1 - d0, 1);
    check_seq("s1", base);
    check("s1_count_holds", cnt1, 6);

    // Offset scan on the POLARITY=0 instance.
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] x;
      x = 10'(i);
      if (!f_model(x)) exp0.push_back(x);
    end
    dn = 0;
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    for (int n = 1; n <= 4000 && dn == 0; n++) begin
      @(negedge clk);
      if (done0) dn = n;
    end
    check("s2_done_cycle", dn, 1026);
    check("s2_len", q0.size(), 1018);
    check("s2_emit_count", cnt0, 1018);
    mism = 0; hits = 0;
    for (int i = 0; i < q0.size(); i++) begin
      if (i >= exp0.size() || q0[i] != exp0[i]) mism++;
      for (int j = 0; j < 6; j++) if (q0[i] == tbl[j].v) hits++;
    end
    check("s2_order_mismatches", mism, 0);
    check("s2_onset_hits", hits, 0);

    // Back-pressure: random ready, 960 held pending for 20 cycles.
    base = q1.size(); d0 = done_cnt1;
    run_scan(1, dn, fv, bzd, bzp, hold);
    check("s3_done_seen", dn > 0, 1);
    check("s3_hold_cycles", hold, 20);
    repeat (4) @(negedge clk);
    check("s3_done_pulses", done_cnt1 - d0, 1);
    check("s3_stability_errors", stab_err, 0);
    check_seq("s3", base);

    // Abort while 709 is pending.
    base = q1.size(); d0 = done_cnt1; hit = 0;
    ready1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int n = 0; n < 2000 && hit == 0; n++) begin
      @(posedge clk); #1;
      if (vv1 && vec1 == 10'd709) begin
        ready1 = 1'b0; abort1 = 1'b1; hit = 1;
      end
    end
    check("s4_709_pending", hit, 1);
    @(posedge clk); #1 abort1 = 1'b0; ready1 = 1'b1;
    @(negedge clk);
    check("s4_valid", vv1, 0);
    check("s4_busy", busy1, 0);
    check("s4_count", cnt1, 2);
    repeat (3) @(negedge clk);
    check("s4_no_done", done_cnt1 - d0, 0);
    check("s4_accepted", q1.size() - base, 2);
    base = q1.size();
    run_scan(0, dn, fv, bzd, bzp, hold);
    check("s4_rescan_done_cycle", dn, 1026);
    check_seq("s4r", base);

    // Start re-pulsed mid-scan has no effect.
    base = q1.size(); d0 = done_cnt1;
    run_scan(2, dn, fv, bzd, bzp, hold);
    check("s5_done_cycle", dn, 1026);
    repeat (4) @(negedge clk);
    check("s5_done_pulses", done_cnt1 - d0, 1);
    check_seq("s5", base);

    // Reset mid-scan with a vector pending.
    ready1 = 1'b0;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (470) @(posedge clk);
    @(negedge clk);
    check("s5_pending_valid", vv1, 1);
    check("s5_pending_vec", vec1, 448);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; ready1 = 1'b1;
    @(negedge clk);
    check("s5_rst_busy", busy1, 0);
    check("s5_rst_valid", vv1, 0);
    check("s5_rst_vec", vec1, 0);
    check("s5_rst_count", cnt1, 0);
    check("s5_rst_done", done1, 0);

    // Start and abort together in IDLE.
    @(posedge clk); #1 start1 = 1'b1; abort1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0; abort1 = 1'b0;
    @(negedge clk);
    check("s6_busy", busy1, 0);
    repeat (3) @(negedge clk);
    check("s6_busy_later", busy1, 0);
    check("s6_valid_later", vv1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/newtpla1_onset_gen.md
# newtpla1_onset_gen

Sequential enumerator for the `newtpla1` single-output function, the counterpart to the combinational detector. The block walks all 1024 input vectors, evaluates the function internally, and streams every vector in the selected set (onset or offset) over a valid/ready interface. It feeds the D-reduction and autosymmetry experiment harness, which consumes minterm lists rather than a truth-table evaluator.

## Interface
- `POLARITY`, default 1. 1 emits onset vectors (f=1); 0 emits offset vectors (f=0).
- `clk` input 1. Single clock, rising edge.
- `rst` input 1. Synchronous, active-high reset.
- `start` input 1. Begins a scan when sampled high in IDLE; ignored otherwise.
- `abort` input 1. Terminates a scan; takes priority over everything except `rst`.
- `busy` output 1. High in SCAN and DRAIN.
- `done` output 1. One-cycle pulse at normal scan completion.
- `vec_valid` output 1. Output vector is held and valid.
- `vec_ready` input 1. Consumer accepts `vec` when `vec_valid & vec_ready`.
- `vec` output 10. Emitted vector, bit i = x_i.
- `emit_count` output 11. Number of vectors accepted in the current or most recent scan.

## Operation
- Function: f = ~x1 & ~x3 & ~x4 & ~x5 & x6 & x7 & (x0 ? (x2 & x9) : x8).
- Match = (f == POLARITY).
- Internal 10-bit index `idx`; candidate vector = idx, bit i drives x_i. Ascending order 0..1023.
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE: `start` -> SCAN, `idx`=0, `emit_count`=0. `vec_valid` stays 0.
  - SCAN, each cycle:
    - Output slot is free when `vec_valid`=0 or a handshake occurs this cycle.
    - No match: `idx` advances.
    - Match and slot free: load `vec`=idx, set `vec_valid`=1, advance `idx`.
    - Match and slot not free: stall; `idx` holds and the same candidate is re-evaluated next cycle.
    - When `idx`=1023 advances (no stall), go to DRAIN. `idx` does not wrap into a second pass.
  - DRAIN: wait until `vec_valid`=0, counting a handshake in the same cycle as clearing it, then go to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- Output register: `vec` and `vec_valid` are stable while `vec_valid & ~vec_ready`. `vec_valid` clears on handshake unless reloaded in the same cycle.
- `emit_count`: increments by 1 on each handshake. 11 bits, so 1024 is representable. It holds its value after DONE until the next accepted `start`.
- `abort` in any state: next cycle IDLE, `vec_valid`=0, `done` stays 0, `emit_count` holds. A handshake in the abort cycle is counted.
- `start` in the same cycle as `abort`: the abort wins and the start is dropped.
- `start` while `busy` or in DONE: ignored.

## Timing
- Reset values: state IDLE, `idx`=0, `busy`=0, `done`=0, `vec_valid`=0, `vec`=0, `emit_count`=0.
- `rst` mid-scan returns all outputs to reset values on the next edge. Any pending vector is dropped.
- `start` sampled at edge T: `busy`=1 from T+1, and idx 0 is evaluated in cycle T+1.
- A match at idx k, evaluated in cycle C with the slot free, gives `vec_valid`=1 and `vec`=k from C+1.
- Throughput: one candidate per cycle. Back-to-back matches stream at one vector per cycle if `vec_ready` is held high.
- With no stalls, idx 1023 is evaluated at T+1024, DRAIN starts at T+1025, and `done` follows once the last vector drains.
- With `vec_ready`=1 throughout, `done`=1 in cycle T+1026 or T+1027.

## Test plan
- POLARITY=1, `vec_ready`=1 constantly, pulse `start` -> emitted sequence exactly 448, 452, 709, 960, 964, 965; `emit_count`=6; single `done` pulse; `busy` falls the same cycle `done` rises.
- POLARITY=0, `vec_ready`=1 -> 1018 vectors in ascending order, none of the six onset values present; `emit_count`=1018.
- POLARITY=1, `vec_ready` toggled pseudo-randomly with 0 held for 20 cycles while 960 is pending -> `vec` stable at 960 through the stall; sequence and count unchanged; no duplicates or losses.
- `abort` asserted while `vec`=709 is pending -> next cycle `vec_valid`=0, `busy`=0, no `done`, `emit_count`=2. A new `start` then produces the full 6-vector sequence from 448.
- `start` re-pulsed mid-scan, plus `rst` asserted mid-scan -> the re-pulse has no effect; the reset clears all outputs to their reset values.
- `start` and `abort` in the same IDLE cycle -> remains IDLE, `busy`=0.
